// File: rtl/delay_line_prog_if.sv
// Sample/config bus of the programmable delay line.
// The master drives samples and control strobes; the slave returns the delayed sample and status.
interface delay_line_prog_if #(
    parameter int gp_data_width = 8,
    parameter int gp_max_stages = 16
);
    localparam int c_dly_width = $clog2(gp_max_stages + 1);

    logic                            i_ena;
    logic signed [gp_data_width-1:0] i_data;
    logic [c_dly_width-1:0]          i_delay;
    logic                            i_delay_load;
    logic                            i_flush;
    logic signed [gp_data_width-1:0] o_data;
    logic                            o_valid;
    logic [c_dly_width-1:0]          o_delay;
    logic                            o_cfg_err;

    modport master (
        output i_ena, i_data, i_delay, i_delay_load, i_flush,
        input  o_data, o_valid, o_delay, o_cfg_err
    );

    modport slave (
        input  i_ena, i_data, i_delay, i_delay_load, i_flush,
        output o_data, o_valid, o_delay, o_cfg_err
    );
endinterface

// File: rtl/delay_line_prog.sv
// Programmable-length sample delay line with fill tracking.
// Delay 0 is a combinational bypass; o_valid marks samples that entered after the last load/flush.
module delay_line_prog #(
    parameter int gp_data_width = 8,
    parameter int gp_max_stages = 16
) (
    input logic              i_clk,
    input logic              i_rst,
    delay_line_prog_if.slave bus
);
    localparam int c_dly_width = $clog2(gp_max_stages + 1);
    localparam logic [c_dly_width-1:0] c_max = c_dly_width'(gp_max_stages);

    typedef enum logic {FILL, RUN} state_t;

    state_t                                     state, state_nxt;
    logic [gp_max_stages-1:0][gp_data_width-1:0] stage;
    logic [c_dly_width-1:0]                     r_delay;
    logic [c_dly_width-1:0]                     r_fill, fill_nxt;
    logic                                       cfg_err;
    logic                                       dly_ovf;

    assign dly_ovf = (bus.i_delay > c_max);

    // Flush wins over shift: the incoming sample is dropped along with the contents.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_flush) begin
            stage <= '0;
        end else if (bus.i_ena) begin
            stage[0] <= bus.i_data;
            for (int k = 1; k < gp_max_stages; k++) stage[k] <= stage[k-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_delay <= c_max;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= bus.i_delay_load && dly_ovf;
            if (bus.i_delay_load) r_delay <= dly_ovf ? c_max : bus.i_delay;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= FILL;
            r_fill <= '0;
        end else begin
            state  <= state_nxt;
            r_fill <= fill_nxt;
        end
    end

    // A load or flush restarts the fill; the shift on that edge is not counted.
    always_comb begin
        state_nxt = state;
        fill_nxt  = r_fill;
        if (bus.i_delay_load || bus.i_flush) begin
            state_nxt = FILL;
            fill_nxt  = '0;
        end else if (state == FILL) begin
            if (r_delay == '0) begin
                state_nxt = RUN;
            end else if (bus.i_ena) begin
                if (r_fill != r_delay) fill_nxt = r_fill + 1'b1;
                if (r_fill == r_delay - 1'b1) state_nxt = RUN;
            end
        end
    end

    // Tap select by comparison keeps the index within the stage range for any r_delay.
    always_comb begin
        bus.o_data = bus.i_data;
        for (int k = 0; k < gp_max_stages; k++) begin
            if (r_delay == c_dly_width'(k + 1)) bus.o_data = stage[k];
        end
    end

    assign bus.o_valid   = (state == RUN);
    assign bus.o_delay   = r_delay;
    assign bus.o_cfg_err = cfg_err;
endmodule

// File: tb/tb_delay_line_prog.sv
// Bench for delay_line_prog: directed sequences, a vector table, then random traffic vs a sample-history model.
module tb_delay_line_prog;
    localparam int DW  = 8;
    localparam int MS  = 16;
    localparam int DLW = $clog2(MS + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    delay_line_prog_if #(.gp_data_width(DW), .gp_max_stages(MS)) bus ();
    delay_line_prog #(.gp_data_width(DW), .gp_max_stages(MS)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: history of shifted-in samples plus counts of edges since the last load/flush.
    logic signed [DW-1:0] m_hist[MS];
    int m_delay, m_cnt, m_edges;
    bit m_err;

    typedef struct {
        bit                 load;
        int                 delay;
        bit                 ena;
        logic signed [DW-1:0] data;
        bit                 e_valid;
        logic signed [DW-1:0] e_data;
        int                 e_delay;
        bit                 e_err;
    } vec_t;
    vec_t vt[7];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(bit r, bit e, logic signed [DW-1:0] d, bit l, int dl, bit f);
        rst              = r;
        bus.i_ena        = e;
        bus.i_data       = d;
        bus.i_delay_load = l;
        bus.i_delay      = DLW'(dl);
        bus.i_flush      = f;
    endtask

    task automatic model_edge();
        if (rst) begin
            foreach (m_hist[k]) m_hist[k] = '0;
            m_delay = MS; m_cnt = 0; m_edges = 0; m_err = 0;
        end else begin
            m_err = bus.i_delay_load && (int'(bus.i_delay) > MS);
            if (bus.i_flush) begin
                foreach (m_hist[k]) m_hist[k] = '0;
            end else if (bus.i_ena) begin
                for (int k = MS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
                m_hist[0] = bus.i_data;
            end
            if (bus.i_delay_load || bus.i_flush) begin
                if (bus.i_delay_load) m_delay = (int'(bus.i_delay) > MS) ? MS : int'(bus.i_delay);
                m_cnt = 0; m_edges = 0;
            end else begin
                m_edges++;
                if (bus.i_ena) m_cnt++;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model();
        logic signed [DW-1:0] md;
        bit mv;
        mv = (m_delay == 0) ? (m_edges >= 1) : (m_cnt >= m_delay);
        md = (m_delay == 0) ? bus.i_data : m_hist[m_delay-1];
        chk("rnd_valid", bus.o_valid, mv);
        chk("rnd_data", bus.o_data, md);
        chk("rnd_delay", bus.o_delay, m_delay);
        chk("rnd_err", bus.o_cfg_err, m_err);
    endtask

    task automatic chk_out(string name, bit v, logic signed [DW-1:0] d, int dl);
        chk({name, "_valid"}, bus.o_valid, v);
        chk({name, "_data"}, bus.o_data, d);
        chk({name, "_delay"}, bus.o_delay, dl);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        tick();
        chk_out("reset", 0, 0, MS);
        chk("reset_err", bus.o_cfg_err, 0);

        // Ramp at default delay: valid after the 16th enabled edge.
        for (int i = 1; i <= 19; i++) begin
            drive(0, 1, DW'(i), 0, 0, 0);
            tick();
            if (i < MS) chk("ramp_fill_valid", bus.o_valid, 0);
            else chk_out("ramp_run", 1, DW'(i - 15), MS);
        end

        // Delay 4 with a 2-cycle enable gap; stages hold 19,18,17,16 at this point.
        drive(0, 0, 0, 1, 4, 0); tick(); chk_out("ld4", 0, 16, 4);
        drive(0, 1, 101, 0, 0, 0); tick(); chk_out("ld4_s1", 0, 17, 4);
        drive(0, 1, 102, 0, 0, 0); tick(); chk_out("ld4_s2", 0, 18, 4);
        drive(0, 0, 77, 0, 0, 0); tick(); chk_out("ld4_gap1", 0, 18, 4);
        drive(0, 0, 78, 0, 0, 0); tick(); chk_out("ld4_gap2", 0, 18, 4);
        drive(0, 1, 103, 0, 0, 0); tick(); chk_out("ld4_s3", 0, 19, 4);
        drive(0, 1, 104, 0, 0, 0); tick(); chk_out("ld4_s4", 1, 101, 4);

        // Flush with enable in RUN: sample 55 must never appear.
        drive(0, 1, 55, 0, 0, 1); tick(); chk_out("flush", 0, 0, 4);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1, DW'(i), 0, 0, 0);
            tick();
            chk_out("flush_refill", i == 4, (i == 4) ? DW'(1) : DW'(0), 4);
        end

        // Reset during fill overrides a simultaneous load.
        drive(0, 0, 0, 1, 4, 0); tick(); chk_out("fill4", 0, 1, 4);
        drive(0, 1, 7, 0, 0, 0); tick(); chk_out("fill4_s1", 0, 2, 4);
        drive(0, 1, 8, 0, 0, 0); tick(); chk_out("fill4_s2", 0, 3, 4);
        drive(1, 1, 9, 1, 2, 0); tick(); chk_out("rst_ld", 0, 0, MS);
        chk("rst_ld_err", bus.o_cfg_err, 0);

        // Bypass and overflow-load vectors; rows apply back to back.
        vt[0] = '{1, 0,      0, 5,  0, 5,  0,  0};
        vt[1] = '{0, 0,      0, -3, 1, -3, 0,  0};
        vt[2] = '{0, 0,      1, 42, 1, 42, 0,  0};
        vt[3] = '{1, MS + 3, 0, 9,  0, 0,  MS, 1};
        vt[4] = '{0, 0,      0, 9,  0, 0,  MS, 0};
        vt[5] = '{1, MS,     0, 9,  0, 0,  MS, 0};
        vt[6] = '{1, MS + 1, 0, 9,  0, 0,  MS, 1};
        for (int i = 0; i < 7; i++) begin
            drive(0, vt[i].ena, vt[i].data, vt[i].load, vt[i].delay, 0);
            tick();
            chk_out($sformatf("vec%0d", i), vt[i].e_valid, vt[i].e_data, vt[i].e_delay);
            chk($sformatf("vec%0d_err", i), bus.o_cfg_err, vt[i].e_err);
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(99) == 0,
                  $urandom_range(9) < 7,
                  DW'($urandom),
                  $urandom_range(19) == 0,
                  (($urandom_range(3) == 0) ? $urandom_range(31) : $urandom_range(6)),
                  $urandom_range(24) == 0);
            tick();
            chk_model();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/delay_line_prog.md
DELAY_LINE_PROG -- requirements
Module: delay_line_prog

Interface
REQ-001 The block SHALL have parameter gp_data_width, default 8, meaning input and output sample bit-width, signed.
REQ-002 The block SHALL have parameter gp_max_stages, default 16, meaning maximum number of delay stages (range 1 to 256).
REQ-003 The block SHALL derive localparam c_dly_width = $clog2(gp_max_stages+1), meaning the width of the delay and fill counters.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 i_clk  input  1  rising-edge clock.
REQ-006 i_rst  input  1  synchronous active-high reset.
REQ-007 i_ena  input  1  synchronous active-high shift enable.
REQ-008 i_data  input  gp_data_width  sample in, signed, MSB:LSB.
REQ-009 i_delay  input  c_dly_width  requested delay in enabled cycles.
REQ-010 i_delay_load  input  1  single-cycle strobe that captures i_delay.
REQ-011 i_flush  input  1  single-cycle strobe that clears the pipeline contents.
REQ-012 o_data  output  gp_data_width  delayed sample.
REQ-013 o_valid  output  1  high when o_data holds a sample that entered after the last load or flush.
REQ-014 o_delay  output  c_dly_width  active delay value.
REQ-015 o_cfg_err  output  1  one-cycle pulse when a load requested i_delay > gp_max_stages.

Function
REQ-016 Storage SHALL be gp_max_stages registers stage[0..gp_max_stages-1].
REQ-017 On each edge with i_ena=1, stage[0] SHALL take i_data and stage[k] SHALL take stage[k-1]; with i_ena=0, all stages SHALL hold.
REQ-018 o_data SHALL be stage[r_delay-1] when r_delay>=1, or i_data combinationally when r_delay=0 (bypass, zero latency).
REQ-019 On i_delay_load=1, r_delay SHALL take min(i_delay, gp_max_stages), and o_cfg_err SHALL pulse high for exactly the next cycle only if i_delay > gp_max_stages.
REQ-020 The control state machine SHALL have two states: FILL (o_valid=0) and RUN (o_valid=1), with o_valid registered and equal to (state==RUN).
REQ-021 A fill counter r_fill SHALL count enabled edges in FILL from 0, saturate at r_delay, and be held in RUN.
REQ-022 FILL->RUN SHALL occur on the edge where i_ena=1 and r_fill==r_delay-1, or on the next edge when r_delay=0 regardless of i_ena.
REQ-023 A load SHALL force state FILL and r_fill=0 on that edge; a shift on the same edge SHALL still occur but SHALL NOT be counted.
REQ-024 A flush SHALL clear all stages to 0 and force FILL with r_fill=0; r_delay SHALL be retained.
REQ-025 Simultaneous flush and load SHALL apply both: stages cleared, new delay captured, FILL, r_fill=0.
REQ-026 Simultaneous flush and i_ena SHALL give priority to the flush: stages cleared and i_data discarded.
REQ-027 RUN SHALL persist until the next load, flush or reset; changes on i_delay without i_delay_load SHALL have no effect.
REQ-028 o_delay SHALL equal r_delay.

Reset
REQ-029 With i_rst=1 at a rising edge, all stages SHALL go to 0, r_delay to gp_max_stages, r_fill to 0, state to FILL, o_valid to 0 and o_cfg_err to 0.
REQ-030 i_rst SHALL override i_ena, i_delay_load and i_flush on the same edge, and a reset mid-fill SHALL discard the fill progress.

Verification
REQ-031 The bench SHALL drive reset, then i_ena=1 with a ramp 1,2,3,... at the default delay 16 -> o_valid rises after the 16th enabled edge with o_data=1, followed by 2,3,... on subsequent cycles.
REQ-032 The bench SHALL load i_delay=4 and then apply i_ena with a 2-cycle gap after the 2nd sample -> o_valid rises after the 4th enabled edge, and o_data holds through the gap.
REQ-033 The bench SHALL load i_delay=0 -> o_valid=1 one edge later and o_data follows i_data in the same cycle.
REQ-034 The bench SHALL load i_delay=gp_max_stages+3 -> o_delay=gp_max_stages and o_cfg_err is high for exactly one cycle.
REQ-035 The bench SHALL assert i_flush together with i_ena in RUN at delay 4 -> all stages read 0, o_valid=0 for 4 enabled edges, and o_delay is unchanged.
REQ-036 The bench SHALL assert i_rst during FILL at delay 4 after 2 samples, together with i_delay_load -> o_delay=gp_max_stages, o_valid=0, and the load is ignored.
